fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch and PC sequencing stage directly upstream of the instruction decoder.
//  Holds the PC, reads instruction memory over a req/valid handshake, and latches the word into the instruction register (INST).
//  Resolves branches from the decoder's BS/OFF plus ALU flags Z/N, and halts on HALT.
//  Each instruction is one FETCH phase (>=1 cycle) followed by one EXEC cycle.
// PARAMETERS
//  PC_WIDTH    16       PC / IMEM address width
//  RESET_PC    16'h0000 PC value loaded at reset
//  INST_WIDTH  16       instruction word width
// PORTS
//  CLK         in   1           system clock, rising edge
//  RST_N       in   1           reset, synchronous, active-low
//  IMEM_REQ    out  1           read request to instruction memory
//  IMEM_ADDR   out  PC_WIDTH    read address (= PC)
//  IMEM_VALID  in   1           IMEM_DATA valid this cycle
//  IMEM_DATA   in   INST_WIDTH  instruction word
//  INST        out  INST_WIDTH  instruction register, feeds decoder
//  INST_VALID  out  1           commit strobe; datapath writes (LD/MW) only when high
//  BS          in   3           decoder branch select: 0 BEQ, 1 BNE, 2 BGEZ, 3 BLTZ, 4-7 none
//  OFF         in   6           decoder branch offset, signed, in instructions
//  HALT        in   1           decoder halt request
//  Z           in   1           ALU zero flag for the current INST
//  N           in   1           ALU negative flag for the current INST
//  PC          out  PC_WIDTH    current program counter
//  HALTED      out  1           processor halted
//  STEP        in   1           single-step pulse (STEP_MODE_EN only)
// BEHAVIOUR
//  Clock/reset: one clock, CLK. RST_N is synchronous and active-low.
//  States: IDLE, FETCH, EXEC, HALTED.
//   - Reset state is IDLE; IDLE -> FETCH unconditionally.
//   - FETCH -> EXEC on IMEM_VALID.
//   - EXEC -> HALTED if HALT=1, otherwise -> FETCH.
//   - HALTED is sticky until reset.
//  Reset values: PC=RESET_PC, INST=0, IMEM_REQ=0, INST_VALID=0, HALTED=0.
//   - Reset in any state, including mid-fetch, abandons the request; a late IMEM_VALID is ignored.
//  FETCH:
//   - IMEM_REQ=1 and IMEM_ADDR=PC, held stable until IMEM_VALID.
//   - On IMEM_VALID, INST<=IMEM_DATA at that edge.
//   - IMEM_VALID outside FETCH is ignored.
//   - Zero-wait memory gives 2 cycles per instruction.
//  EXEC:
//   - INST_VALID=1 for exactly this one cycle; decoder outputs and Z/N are sampled at its end.
//   - Taken condition:
//      BS=0: Z
//      BS=1: !Z
//      BS=2: !N
//      BS=3: N
//      BS=4-7: never taken
//   - PC_inc = PC + 2.
//   - Taken: PC <= PC_inc + {sext(OFF),1'b0}. Not taken: PC <= PC_inc.
//   - All PC arithmetic is modulo 2^PC_WIDTH; wraps silently.
//   - HALT=1 wins over any branch; PC is not updated.
//  HALTED:
//   - HALTED=1, IMEM_REQ=0, INST_VALID=0.
//   - PC and INST are frozen at the halting instruction.
//  INST is updated only in FETCH on IMEM_VALID; it is stable through EXEC.
// CONFIGURATION
//  STEP_MODE_EN defined:
//   - Adds the STEP port.
//   - EXEC -> FETCH waits in a STEP_WAIT state until STEP=1.
//   - INST_VALID stays 1 only for the first EXEC cycle; the PC update happens in that cycle.
//   - STEP=1 outside STEP_WAIT is ignored.
//   - HALT still goes straight to HALTED.
//  STEP_MODE_EN undefined: no STEP port and no STEP_WAIT state; EXEC -> FETCH directly.
// TESTING
//  T1 Reset: RST_N=0 for 2 cycles, release -> IMEM_REQ=0 in IDLE, then IMEM_REQ=1 with IMEM_ADDR=0x0000 next cycle.
//  T2 Sequential: zero-wait memory with ADDI words -> PC 0,2,4,6 on successive EXECs; INST_VALID every 2nd cycle.
//  T3 Wait states: IMEM_VALID delayed 3 cycles -> IMEM_REQ/IMEM_ADDR held steady 4 cycles; INST_VALID single pulse.
//  T4 Branch: PC=0x0010, BS=0, OFF=6'h3E, Z=1 -> PC=0x000E. Same with Z=0 -> PC=0x0012. BS=3 with N=1, OFF=6'h02 -> PC=0x0016.
//  T5 Wrap and halt: PC=0xFFFE, BS=4 -> PC=0x0000. Then HALT=1 with BS=0, Z=1 -> HALTED=1, PC unchanged, IMEM_REQ=0 forever.
//  T6 Reset mid-fetch: assert RST_N=0 while IMEM_REQ=1, return IMEM_VALID one cycle later -> INST stays 0; PC=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing and instruction fetch ahead of the decoder.
// Ports: CLK/RST_N, IMEM_* fetch handshake, INST/INST_VALID to the decoder,
// BS/OFF/HALT/Z/N branch inputs, PC, HALTED, and STEP when STEP_MODE_EN is defined.
module fetch_unit #(
  parameter int PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int INST_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  output logic                  IMEM_REQ,
  output logic [PC_WIDTH-1:0]   IMEM_ADDR,
  input  logic                  IMEM_VALID,
  input  logic [INST_WIDTH-1:0] IMEM_DATA,
  output logic [INST_WIDTH-1:0] INST,
  output logic                  INST_VALID,
  input  logic [2:0]            BS,
  input  logic [5:0]            OFF,
  input  logic                  HALT,
  input  logic                  Z,
  input  logic                  N,
  output logic [PC_WIDTH-1:0]   PC,
  output logic                  HALTED
`ifdef STEP_MODE_EN
  ,
  input  logic                  STEP
`endif
);

`ifdef STEP_MODE_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_STEP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;
`endif

  state_t                state;
  state_t                state_nx;
  logic [PC_WIDTH-1:0]   pc;
  logic [PC_WIDTH-1:0]   pc_nx;
  logic [INST_WIDTH-1:0] inst;
  logic [INST_WIDTH-1:0] inst_nx;
  logic                  taken;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic [PC_WIDTH-1:0]   off_ext;

  // OFF counts instructions; byte offset is OFF*2
  assign pc_inc  = pc + PC_WIDTH'(2);
  assign off_ext = {{(PC_WIDTH-7){OFF[5]}}, OFF, 1'b0};

  always_comb begin
    taken = 1'b0;
    unique case (BS)
      3'd0:    taken = Z;
      3'd1:    taken = !Z;
      3'd2:    taken = !N;
      3'd3:    taken = N;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      inst  <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      inst  <= inst_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    inst_nx  = inst;
    unique case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        if (IMEM_VALID) begin
          inst_nx  = IMEM_DATA;
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        // halt wins over any branch and freezes the PC
        if (HALT) begin
          state_nx = S_HALT;
        end else begin
          pc_nx = taken ? (pc_inc + off_ext) : pc_inc;
`ifdef STEP_MODE_EN
          state_nx = S_STEP;
`else
          state_nx = S_FETCH;
`endif
        end
      end
      S_HALT: state_nx = S_HALT;
`ifdef STEP_MODE_EN
      S_STEP: begin
        if (STEP) state_nx = S_FETCH;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  assign IMEM_REQ   = (state == S_FETCH);
  assign IMEM_ADDR  = pc;
  assign INST_VALID = (state == S_EXEC);
  assign HALTED     = (state == S_HALT);
  assign INST       = inst;
  assign PC         = pc;

endmodule
